// File: rtl/mul_share_ctrl.sv
`default_nettype none
// ============================================================================
// mul_share_ctrl : round-robin arbiter/sequencer sharing one repeated-addition
//                  multiplier datapath among NUM_REQ requesters, with watchdog.
// Revision 1.0
// ============================================================================
module mul_share_ctrl #(
  parameter int NUM_REQ  = 4,
  parameter int WIDTH    = 16,
  parameter int MAX_ITER = 1024,
  parameter int ID_W     = $clog2(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*WIDTH-1:0]   opa,
  input  logic [NUM_REQ*WIDTH-1:0]   opb,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [NUM_REQ-1:0]         done,
  output logic                       err,
  output logic [WIDTH-1:0]           result,
  output logic [ID_W-1:0]            result_id,
  output logic                       busy,
  output logic [WIDTH-1:0]           bus_out,
  output logic                       ldA,
  output logic                       ldB,
  output logic                       ldP,
  output logic                       clrP,
  output logic                       decB,
  input  logic                       eqz,
  input  logic [WIDTH-1:0]           prod_in
);

  localparam int c_IT_W = $clog2(MAX_ITER + 1);
  localparam int c_SW   = ID_W + 1;

  localparam logic [2:0] c_IDLE = 3'd0;
  localparam logic [2:0] c_LDA  = 3'd1;
  localparam logic [2:0] c_LDB  = 3'd2;
  localparam logic [2:0] c_ACC  = 3'd3;
  localparam logic [2:0] c_CAP  = 3'd4;
  localparam logic [2:0] c_DONE = 3'd5;

  logic [2:0]           r_state;
  logic [2:0]           w_next;
  logic [ID_W-1:0]      r_id;
  logic [ID_W-1:0]      r_rr;
  logic [ID_W-1:0]      w_win;
  logic [ID_W-1:0]      w_id_inc;
  logic [c_SW-1:0]      w_sum;
  logic [c_IT_W-1:0]    r_iter;
  logic                 r_abort;
  logic [WIDTH-1:0]     r_result;
  logic [ID_W-1:0]      r_result_id;
  logic                 w_any;
  logic                 w_limit;
  logic [2*NUM_REQ-1:0] w_req2;
  logic [NUM_REQ-1:0]   w_rot;
  logic [NUM_REQ-1:0]   w_id_oh;
  logic [WIDTH-1:0]     w_opa [NUM_REQ];
  logic [WIDTH-1:0]     w_opb [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign w_opa[gi] = opa[gi*WIDTH +: WIDTH];
      assign w_opb[gi] = opb[gi*WIDTH +: WIDTH];
    end
  endgenerate

  assign w_any    = |req;
  assign w_req2   = {req, req};
  assign w_rot    = w_req2[r_rr +: NUM_REQ];
  assign w_id_inc = (r_id == ID_W'(NUM_REQ - 1)) ? '0 : r_id + 1'b1;
  assign w_limit  = (r_iter == c_IT_W'(MAX_ITER));
  assign w_id_oh  = NUM_REQ'(1) << r_id;

  // Requests rotated so bit 0 is the rr pointer; the lowest set bit wins.
  always_comb begin
    w_win = '0;
    w_sum = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_sum = {1'b0, r_rr} + c_SW'(k);
        if (w_sum >= c_SW'(NUM_REQ)) begin
          w_sum = w_sum - c_SW'(NUM_REQ);
        end
        w_win = w_sum[ID_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE: if (w_any) w_next = c_LDA;
      c_LDA:  w_next = c_LDB;
      c_LDB:  w_next = c_ACC;
      c_ACC: begin
        if (eqz) begin
          w_next = c_CAP;
        end else if (w_limit) begin
          w_next = c_DONE;
        end
      end
      c_CAP:  w_next = c_DONE;
      c_DONE: w_next = c_IDLE;
      default: w_next = c_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_id        <= '0;
      r_rr        <= '0;
      r_iter      <= '0;
      r_abort     <= 1'b0;
      r_result    <= '0;
      r_result_id <= '0;
    end else begin
      case (r_state)
        c_IDLE: if (w_any) r_id <= w_win;
        c_LDB:  r_iter <= '0;
        c_ACC: begin
          if (!eqz) begin
            if (w_limit) begin
              r_abort     <= 1'b1;
              r_result    <= '0;
              r_result_id <= r_id;
            end else begin
              r_iter <= r_iter + 1'b1;
            end
          end
        end
        c_CAP: begin
          r_result    <= prod_in;
          r_result_id <= r_id;
        end
        c_DONE: begin
          r_rr    <= w_id_inc;
          r_abort <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign result    = r_result;
  assign result_id = r_result_id;

  // The watchdog cycle itself issues no strobes, so exactly MAX_ITER accumulate.
  always_comb begin
    busy    = (r_state != c_IDLE);
    gnt     = busy ? w_id_oh : '0;
    done    = '0;
    err     = 1'b0;
    bus_out = '0;
    ldA     = 1'b0;
    ldB     = 1'b0;
    ldP     = 1'b0;
    clrP    = 1'b0;
    decB    = 1'b0;
    case (r_state)
      c_LDA: begin
        bus_out = w_opa[r_id];
        ldA     = 1'b1;
      end
      c_LDB: begin
        bus_out = w_opb[r_id];
        ldB     = 1'b1;
        clrP    = 1'b1;
      end
      c_ACC: begin
        ldP  = ~eqz & ~w_limit;
        decB = ~eqz & ~w_limit;
      end
      c_DONE: begin
        done = w_id_oh;
        err  = r_abort;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire
